sram_burst_master: RTL and testbench
====================================

SRAM_BURST_MASTER -- requirements
Module: sram_burst_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, SRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, SRAM word width.
REQ-003 SHALL have parameter SRAM_DEPTH, default 256, number of SRAM words.
REQ-004 SHALL have port CK  input  1  clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port RST_N  input  1  reset; synchronous, active-low.
REQ-006 SHALL have cmd_valid input 1, cmd_ready output 1, cmd_op input 2 (00 read, 01 write, 10 clear, 11 reserved), cmd_addr input ADDR_WIDTH, cmd_len input ADDR_WIDTH (word count minus 1).
REQ-007 SHALL have wr_valid input 1, wr_ready output 1, wr_data input DATA_WIDTH.
REQ-008 SHALL have rd_valid output 1, rd_ready input 1, rd_data output DATA_WIDTH.
REQ-009 SHALL have busy output 1 (high outside IDLE) and done output 1 (one-cycle pulse at burst end).
REQ-010 SHALL have SRAM-side ports sram_cs, sram_we outputs 1; sram_a output ADDR_WIDTH; sram_d output DATA_WIDTH; sram_q input DATA_WIDTH (registered read, valid one cycle after sram_cs, held while sram_cs low).

Function
REQ-011 SHALL implement FSM states IDLE, WRITE, READ, CLEAR, DONE.
REQ-012 IDLE: cmd_ready=1; cmd_valid&&cmd_ready latches addr/len/op, moves to WRITE/READ/CLEAR next cycle; op 11 goes directly to DONE without SRAM access.
REQ-013 WRITE: wr_ready=1; each wr_valid&&wr_ready drives sram_cs=1, sram_we=1, sram_a=current addr, sram_d=wr_data in the same cycle (combinational pass-through); no SRAM access without handshake.
REQ-014 READ: issues sram_cs=1, sram_we=0 only when a slot is free in a 2-entry output FIFO, counting the in-flight read; sram_q captured into FIFO the cycle after issue.
REQ-015 rd_valid SHALL equal FIFO non-empty; rd_data = FIFO head; pop on rd_valid&&rd_ready; full-rate (1 word/cycle) when rd_ready held high.
REQ-016 Address SHALL increment per access and wrap from SRAM_DEPTH-1 to 0; word counter counts cmd_len+1 accesses.
REQ-017 WRITE/CLEAR exit to DONE the cycle after the last access; READ exits to DONE the cycle after the last word is popped.
REQ-018 DONE: done=1 for exactly one cycle, busy=0 not yet asserted until return to IDLE the next cycle; cmd_ready=0 in DONE.
REQ-019 cmd_ready=0, wr_ready=0 outside their states; rd_ready ignored when FIFO empty; wr_valid outside WRITE ignored.
REQ-020 cmd_len=0 SHALL perform exactly one access.

Reset
REQ-021 RST_N low at a CK edge SHALL force IDLE, clear FIFO, counters, address; outputs: cmd_ready=1 after release, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, sram_cs=0, sram_we=0, sram_a=0, sram_d=0.
REQ-022 Reset mid-burst SHALL abandon the burst without done pulse; in-flight read data discarded.

Configuration
REQ-023 With SRAM_BURST_CLEAR_EN defined, op 10 SHALL write zero to cmd_len+1 words at one word per cycle (sram_cs=1, sram_we=1, sram_d=0), no wr handshake.
REQ-024 Without SRAM_BURST_CLEAR_EN, op 10 SHALL be treated as reserved (direct to DONE) and CLEAR logic SHALL not be built.

Structure
REQ-025 Shared package SHALL hold the op encodings (OP_READ, OP_WRITE, OP_CLEAR, OP_RSVD) and FSM state typedef.
REQ-026 The 2-entry output FIFO SHALL be sub-module sram_rd_fifo; SRAM itself is external (sram_wrapper instance in the bench).

Verification
REQ-027 Write addr 0x10 len 3 data 1,2,3,4 with wr_valid constant -> 4 consecutive write cycles at 0x10..0x13, done pulse 1 cycle after last.
REQ-028 Read addr 0x10 len 3, rd_ready=1 -> rd_data 1,2,3,4 on consecutive cycles, first valid 2 cycles after issue, then done.
REQ-029 Read same range with rd_ready toggled 1/0 -> no loss/duplication, sram_cs never issued with 2 words buffered+in-flight.
REQ-030 Write addr 0xFE len 3 -> accesses at 0xFE, 0xFF, 0x00, 0x01.
REQ-031 With SRAM_BURST_CLEAR_EN, clear addr 0x10 len 1 then read -> 0,0; without macro -> no SRAM write, done next cycle.
REQ-032 RST_N low during third read word -> rd_valid=0, busy=0, no done; new command accepted after release.

Source files
------------

// File: rtl/sram_burst_master_pkg.sv
// sram_burst_master_pkg: command op encodings and FSM state type shared by the burst master
package sram_burst_master_pkg;
   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;
   typedef enum logic [2:0] {IDLE, WRITE, READ, CLEAR, DONE} state_t;
endpackage

// File: rtl/sram_rd_fifo.sv
// sram_rd_fifo: 2-entry read-data FIFO, head reads as zero when empty
module sram_rd_fifo #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  ck,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  valid,
   output logic [1:0]            count
);
   logic [DATA_WIDTH-1:0] mem [2];
   logic                  wp, rp;
   // storage, pointers and occupancy; pop is only asserted when non-empty
   always_ff @(posedge ck)
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wp <= 1'b0;
         rp <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            mem[wp] <= din;
            wp <= ~wp;
         end
         if (pop) rp <= ~rp;
         count <= count + 2'(push) - 2'(pop);
      end
   assign valid = count != 2'd0;
   assign dout = valid ? mem[rp] : '0;
endmodule

// File: rtl/sram_wrapper.sv
// sram_wrapper: single-port SRAM, registered read output held while cs is low
module sram_wrapper #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int SRAM_DEPTH = 256
) (
   input  logic                  ck,
   input  logic                  cs,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q
);
   logic [DATA_WIDTH-1:0] mem [SRAM_DEPTH];
   // write on cs&we, otherwise a cs read updates q one cycle later
   always_ff @(posedge ck)
      if (cs) begin
         if (we) mem[a] <= d;
         else q <= mem[a];
      end
endmodule

// File: rtl/sram_burst_master.sv
// sram_burst_master: burst read/write/clear engine for an external SRAM; clear built only with SRAM_BURST_CLEAR_EN
module sram_burst_master
   import sram_burst_master_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int SRAM_DEPTH = 256
) (
   input  logic                  CK,
   input  logic                  RST_N,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [ADDR_WIDTH-1:0] cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  sram_cs,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);
   localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(SRAM_DEPTH - 1);
`ifdef SRAM_BURST_CLEAR_EN
   localparam state_t CLR_NX = CLEAR;
`else
   localparam state_t CLR_NX = DONE;
`endif
   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] addr, len, addr_inc;
   logic [ADDR_WIDTH:0]   cnt, pcnt;
   logic                  inflight, acc, issue, pop;
   logic [1:0]            fcnt;
   logic [2:0]            occ;
   assign addr_inc = (addr == LAST_A) ? '0 : addr + ADDR_WIDTH'(1);
   assign pop = rd_valid && rd_ready;
   assign occ = {1'b0, fcnt} + {2'b0, inflight} - {2'b0, pop};
   assign busy = state != IDLE;
   assign sram_cs = acc;
   assign sram_a = addr;
   sram_rd_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
      .ck(CK), .rst_n(RST_N), .push(inflight), .pop(pop), .din(sram_q),
      .dout(rd_data), .valid(rd_valid), .count(fcnt)
   );
   // next state and per-state handshake/SRAM strobes
   always_comb begin
      state_nx = state;
      cmd_ready = 1'b0;
      wr_ready = 1'b0;
      acc = 1'b0;
      issue = 1'b0;
      sram_we = 1'b0;
      sram_d = '0;
      done = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid)
               state_nx = (cmd_op == OP_WRITE) ? WRITE : (cmd_op == OP_READ) ? READ : (cmd_op == OP_CLEAR) ? CLR_NX : DONE;
         end
         WRITE: begin
            wr_ready = 1'b1;
            acc = wr_valid;
            sram_we = wr_valid;
            sram_d = wr_valid ? wr_data : '0;
            if (wr_valid && cnt == {1'b0, len}) state_nx = DONE;
         end
         READ: begin
            issue = (cnt <= {1'b0, len}) && (occ < 3'd2);
            acc = issue;
            if (pop && pcnt == {1'b0, len}) state_nx = DONE;
         end
`ifdef SRAM_BURST_CLEAR_EN
         CLEAR: begin
            acc = 1'b1;
            sram_we = 1'b1;
            if (cnt == {1'b0, len}) state_nx = DONE;
         end
`endif
         DONE: begin
            done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   // state, burst address/counters and the one-cycle read-in-flight flag
   always_ff @(posedge CK)
      if (!RST_N) begin
         state <= IDLE;
         addr <= '0;
         len <= '0;
         cnt <= '0;
         pcnt <= '0;
         inflight <= 1'b0;
      end else begin
         state <= state_nx;
         inflight <= issue;
         if (state == IDLE && cmd_valid) begin
            addr <= cmd_addr;
            len <= cmd_len;
            cnt <= '0;
            pcnt <= '0;
         end else begin
            if (acc) begin
               addr <= addr_inc;
               cnt <= cnt + (ADDR_WIDTH+1)'(1);
            end
            if (pop) pcnt <= pcnt + (ADDR_WIDTH+1)'(1);
         end
      end
endmodule

// File: tb/tb_sram_burst_master.sv
// tb_sram_burst_master: directed bursts checked against a queue/array model of SRAM traffic
module tb_sram_burst_master;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int DEPTH = 256;
   logic CK = 1'b0, RST_N = 1'b0;
   logic cmd_valid = 1'b0, cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
   logic wr_valid = 1'b0, wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic rd_valid, rd_ready = 1'b0;
   logic [DW-1:0] rd_data;
   logic busy, done, sram_cs, sram_we;
   logic [AW-1:0] sram_a;
   logic [DW-1:0] sram_d, sram_q;
   int checks = 0, failures = 0;
   logic [DW-1:0] mem_m [DEPTH];
   logic [AW-1:0] exp_wa[$], exp_ra[$];
   logic [DW-1:0] exp_wd[$], exp_rd[$];
   logic [DW-1:0] wdata[$];
   int tb_buf = 0;
   int tb_inflight = 0;
   int dn, na, fr;

   sram_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRAM_DEPTH(DEPTH)) dut (
      .CK(CK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .busy(busy), .done(done), .sram_cs(sram_cs), .sram_we(sram_we), .sram_a(sram_a),
      .sram_d(sram_d), .sram_q(sram_q)
   );
   sram_wrapper #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRAM_DEPTH(DEPTH)) u_sram (
      .ck(CK), .cs(sram_cs), .we(sram_we), .a(sram_a), .d(sram_d), .q(sram_q)
   );

   always #5 CK = ~CK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_write(input int a, input int l);
      for (int i = 0; i <= l; i++) begin
         exp_wa.push_back(AW'((a + i) % DEPTH));
         exp_wd.push_back(wdata[i]);
         mem_m[(a + i) % DEPTH] = wdata[i];
      end
   endtask

   task automatic model_read(input int a, input int l);
      for (int i = 0; i <= l; i++) begin
         exp_ra.push_back(AW'((a + i) % DEPTH));
         exp_rd.push_back(mem_m[(a + i) % DEPTH]);
      end
   endtask

   // scoreboard: every SRAM access, FIFO level and popped word against the model
   always @(negedge CK) begin
      if (!RST_N) begin
         exp_wa.delete(); exp_wd.delete(); exp_ra.delete(); exp_rd.delete();
         tb_buf = 0;
         tb_inflight = 0;
      end else begin
         chk("rd_valid_level", rd_valid, tb_buf > 0);
         if (sram_cs && sram_we) begin
            if (exp_wa.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               chk("write_addr", sram_a, exp_wa.pop_front());
               chk("write_data", sram_d, exp_wd.pop_front());
            end
         end
         if (sram_cs && !sram_we) begin
            if (exp_ra.size() == 0) chk("unexpected_read", 1, 0);
            else chk("read_addr", sram_a, exp_ra.pop_front());
            chk("read_slot_free", (tb_buf + tb_inflight - int'(rd_valid && rd_ready)) < 2, 1);
         end
         if (rd_valid && rd_ready) begin
            if (exp_rd.size() == 0) chk("unexpected_pop", 1, 0);
            else chk("rd_data", rd_data, exp_rd.pop_front());
         end
         tb_buf = tb_buf + tb_inflight - int'(rd_valid && rd_ready);
         tb_inflight = int'(sram_cs && !sram_we);
      end
   end

   task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] l);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l;
      @(negedge CK);
      chk("cmd_ready_idle", cmd_ready, 1);
      @(posedge CK); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic run(input bit tog, output int done_n, output int nacc, output int first_rv);
      int idx = 0;
      bit hs;
      done_n = 0; nacc = 0; first_rv = 0;
      wr_valid = wdata.size() > 0;
      wr_data = wr_valid ? wdata[0] : '0;
      rd_ready = 1'b1;
      for (int n = 1; n <= 200 && done_n == 0; n++) begin
         @(negedge CK);
         if (sram_cs) nacc++;
         if (rd_valid && first_rv == 0) first_rv = n;
         if (done) done_n = n;
         hs = wr_valid && wr_ready;
         @(posedge CK); #1;
         if (hs) begin
            idx++;
            if (idx < wdata.size()) wr_data = wdata[idx];
            else begin wr_valid = 1'b0; wr_data = '0; end
         end
         if (tog) rd_ready = ~rd_ready;
      end
      wr_valid = 1'b0;
      rd_ready = 1'b1;
      if (done_n == 0) chk("burst_timeout", 0, 1);
      @(negedge CK);
      chk("post_done_low", done, 0);
      chk("post_busy_low", busy, 0);
      chk("post_cmd_ready", cmd_ready, 1);
      chk("post_queues_empty", exp_wa.size() + exp_ra.size() + exp_rd.size(), 0);
      @(posedge CK); #1;
   endtask

   initial begin
      repeat (3) @(posedge CK);
      #1 RST_N = 1'b1;
      @(negedge CK);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cs", sram_cs, 0);
      chk("rst_we", sram_we, 0);
      chk("rst_a", sram_a, 0);
      chk("rst_d", sram_d, 0);
      @(posedge CK); #1;

      wdata = '{32'd1, 32'd2, 32'd3, 32'd4};
      model_write(8'h10, 3);
      send_cmd(2'b01, 8'h10, 8'd3);
      run(0, dn, na, fr);
      chk("wr_done_cycle", dn, 5);
      chk("wr_access_count", na, 4);

      wdata.delete();
      model_read(8'h10, 3);
      send_cmd(2'b00, 8'h10, 8'd3);
      run(0, dn, na, fr);
      chk("rd_first_valid", fr, 3);
      chk("rd_done_cycle", dn, 7);
      chk("rd_access_count", na, 4);

      model_read(8'h10, 3);
      send_cmd(2'b00, 8'h10, 8'd3);
      run(1, dn, na, fr);
      chk("rdtog_access_count", na, 4);

      wdata = '{32'hA, 32'hB, 32'hC, 32'hD};
      model_write(8'hFE, 3);
      chk("model_wrap_pin", mem_m[0], 32'hC);
      send_cmd(2'b01, 8'hFE, 8'd3);
      run(0, dn, na, fr);
      chk("wrap_done_cycle", dn, 5);
      wdata.delete();
      model_read(8'hFE, 3);
      send_cmd(2'b00, 8'hFE, 8'd3);
      run(0, dn, na, fr);
      chk("wrap_rd_done_cycle", dn, 7);

`ifdef SRAM_BURST_CLEAR_EN
      wdata = '{32'd0, 32'd0};
      model_write(8'h10, 1);
      wdata.delete();
      send_cmd(2'b10, 8'h10, 8'd1);
      run(0, dn, na, fr);
      chk("clr_done_cycle", dn, 3);
      chk("clr_access_count", na, 2);
`else
      send_cmd(2'b10, 8'h10, 8'd1);
      run(0, dn, na, fr);
      chk("clr_rsvd_done_cycle", dn, 1);
      chk("clr_rsvd_no_access", na, 0);
`endif
      model_read(8'h10, 1);
      send_cmd(2'b00, 8'h10, 8'd1);
      run(0, dn, na, fr);
      chk("clr_readback_done", dn, 5);

      send_cmd(2'b11, 8'h20, 8'd5);
      run(0, dn, na, fr);
      chk("rsvd_done_cycle", dn, 1);
      chk("rsvd_no_access", na, 0);

      model_read(8'h10, 3);
      send_cmd(2'b00, 8'h10, 8'd3);
      rd_ready = 1'b1;
      repeat (4) begin @(negedge CK); @(posedge CK); #1; end
      RST_N = 1'b0;
      @(negedge CK);
      chk("rst_mid_word3", rd_data, 3);
      @(posedge CK); #1;
      @(negedge CK);
      chk("rst_mid_rd_valid", rd_valid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      chk("rst_mid_cs", sram_cs, 0);
      @(posedge CK); #1;
      RST_N = 1'b1;
      repeat (2) begin
         @(negedge CK);
         chk("rst_rel_done", done, 0);
         chk("rst_rel_cmd_ready", cmd_ready, 1);
         @(posedge CK); #1;
      end

      model_read(8'h12, 0);
      send_cmd(2'b00, 8'h12, 8'd0);
      run(0, dn, na, fr);
      chk("len0_access_count", na, 1);
      chk("len0_done_cycle", dn, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
